dts_ctrl: RTL and testbench
===========================

// Module: dts_ctrl
// PURPOSE
//  Sequencer for the DTSA digital temperature sensor. Drives DTSI3..DTSI0 and
//  measures the DTSO pulse density over a fixed window, returning an unsigned code.
//  Supports one-shot and continuous conversion, with a hysteresis over-temp alarm.
//  Sits between the DTSA instance and fabric housekeeping logic.
// PARAMETERS
//  WARMUP_CYC  64  sensor settle cycles after enable, before counting (>=1)
//  WIN_LOG2    8   measurement window = 2**WIN_LOG2 cycles; RES_W = WIN_LOG2 (localparam)
// PORTS
//  CLK     in   1      sole clock, rising edge
//  RSTN    in   1      asynchronous active-low reset
//  START   in   1      conversion request, sampled only in IDLE
//  CONT    in   1      continuous mode; re-measure after each DONE while high
//  RANGE   in   2      sensor range select, latched on accepted START
//  THR_HI  in   RES_W  alarm set threshold
//  THR_LO  in   RES_W  alarm clear threshold
//  DTSO    in   1      sensor output, asynchronous to CLK
//  DTSI0   out  1      sensor enable
//  DTSI1   out  1      sample strobe
//  DTSI2   out  1      RANGE[0] latched
//  DTSI3   out  1      RANGE[1] latched
//  BUSY    out  1      high in any state except IDLE
//  VALID   out  1      one-cycle pulse when RESULT updates
//  RESULT  out  RES_W  last completed measurement
//  ALARM   out  1      over-temperature flag with hysteresis
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, latched range 0, sync FFs 0.
//  Reset is asynchronous: takes effect immediately, including mid-conversion.
//  DTSO passes through 2-FF synchronizer; only the synchronized value is counted.
//  FSM: IDLE -> WARMUP -> MEASURE -> DONE -> (MEASURE if CONT else IDLE).
//  IDLE: DTSI0=DTSI1=0. START=1 on an edge -> WARMUP next cycle; latch RANGE.
//  WARMUP: DTSI0=1. Stays exactly WARMUP_CYC cycles, then -> MEASURE.
//  MEASURE: DTSI0=DTSI1=1. Stays exactly 2**WIN_LOG2 cycles.
//  Each MEASURE cycle adds sync DTSO to a (WIN_LOG2+1)-bit count.
//  DONE (1 cycle): DTSI0=1, DTSI1=0. RESULT <= min(count, 2**RES_W-1).
//  VALID=1 for that cycle; count cleared.
//  Saturation: all-high window (count=2**WIN_LOG2) reports 2**RES_W-1.
//  Latency: START at edge N -> VALID high in cycle N+1+WARMUP_CYC+2**WIN_LOG2.
//  Continuous: DONE->MEASURE with no re-warmup; VALID period 2**WIN_LOG2+1 cycles.
//  CONT is sampled only in DONE. Dropping CONT mid-MEASURE completes that window.
//  START outside IDLE is ignored, and is not queued.
//  RANGE changes outside IDLE have no effect until the next accepted START.
//  ALARM is updated only in the DONE cycle, from the new RESULT value:
//   new>=THR_HI sets ALARM; new<=THR_LO clears it; otherwise ALARM holds.
//   If both conditions are true (THR_LO>=THR_HI), set wins.
//  Threshold changes take effect at the next DONE; ALARM never changes elsewhere.
//  ALARM and RESULT persist across IDLE; only RSTN clears them.
// TESTING (WARMUP_CYC=4, WIN_LOG2=4 -> RES_W=4, window 16)
//  Reset: RSTN low -> all outputs 0. Release, START=0 for 10 cycles -> BUSY=0, DTSI0=0.
//  One-shot saturation: DTSO=1, START pulse at edge N, RANGE=2'b10.
//   -> BUSY from N+1, DTSI3..2=10, VALID at N+21, RESULT=15, then IDLE.
//  Half density: DTSO toggles each cycle, one-shot -> RESULT=8; DTSO=0 -> RESULT=0.
//  Continuous: CONT=1, START -> VALID pulses every 17 cycles and DTSI0 stays 1.
//   Drop CONT mid-window -> one more VALID, then IDLE with DTSI0=0.
//  Hysteresis: THR_HI=12, THR_LO=4; results 13,8,3 -> ALARM 1,1,0.
//   With THR_LO=12, THR_HI=4, result 8 -> ALARM 1 (set wins).
//  Reset and START abuse: RSTN low mid-MEASURE -> outputs 0 at once, no VALID, IDLE.
//   START repeated while BUSY -> exactly one VALID.

Source files
------------

// File: rtl/dts_ctrl.sv
// Sequencer for the DTSA temperature sensor: warms the sensor up, counts synchronized
// DTSO pulses over a 2**WIN_LOG2-cycle window and reports a saturating code plus alarm.
module dts_ctrl #(
   parameter int WARMUP_CYC = 64,
   parameter int WIN_LOG2   = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic                cont,
   input  logic [1:0]          range,
   input  logic [WIN_LOG2-1:0] thr_hi,
   input  logic [WIN_LOG2-1:0] thr_lo,
   input  logic                dtso,
   output logic                dtsi0,
   output logic                dtsi1,
   output logic                dtsi2,
   output logic                dtsi3,
   output logic                busy,
   output logic                valid,
   output logic [WIN_LOG2-1:0] result,
   output logic                alarm
);

   // state     | meaning
   // S_IDLE    | sensor off, waiting for start
   // S_WARMUP  | sensor enabled, settling for WARMUP_CYC cycles
   // S_MEASURE | strobe high, accumulating synchronized dtso for one window
   // S_DONE    | one cycle: result/alarm/valid presented, then re-measure or idle

   localparam int RES_W   = WIN_LOG2;
   localparam int WIN     = 2**WIN_LOG2;
   localparam int TMR_MAX = (WARMUP_CYC > WIN) ? WARMUP_CYC : WIN;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam logic [TMR_W-1:0] WARM_LD = TMR_W'(WARMUP_CYC - 1);
   localparam logic [TMR_W-1:0] WIN_LD  = TMR_W'(WIN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WARMUP,
      S_MEASURE,
      S_DONE
   } state_t;

   state_t            state;
   logic [TMR_W-1:0]  tmr;
   logic [WIN_LOG2:0] cnt;
   logic              dtso_m;
   logic              dtso_s;

   logic [WIN_LOG2:0] sum;
   logic [RES_W-1:0]  res_new;
   logic              alarm_new;

   // dtso is asynchronous to clk; only dtso_s may feed the counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dtso_m <= 1'b0;
         dtso_s <= 1'b0;
      end else begin
         dtso_m <= dtso;
         dtso_s <= dtso_m;
      end
   end

   // last window sample is folded in here so result is ready together with valid
   always_comb begin
      sum     = cnt + {{WIN_LOG2{1'b0}}, dtso_s};
      res_new = sum[WIN_LOG2] ? {RES_W{1'b1}} : sum[RES_W-1:0];
      alarm_new = alarm;
      if (res_new >= thr_hi)
         alarm_new = 1'b1;
      else if (res_new <= thr_lo)
         alarm_new = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= S_IDLE;
         tmr    <= '0;
         cnt    <= '0;
         dtsi0  <= 1'b0;
         dtsi1  <= 1'b0;
         dtsi2  <= 1'b0;
         dtsi3  <= 1'b0;
         busy   <= 1'b0;
         valid  <= 1'b0;
         result <= '0;
         alarm  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               valid <= 1'b0;
               if (start) begin
                  state <= S_WARMUP;
                  tmr   <= WARM_LD;
                  dtsi0 <= 1'b1;
                  dtsi1 <= 1'b0;
                  dtsi2 <= range[0];
                  dtsi3 <= range[1];
                  busy  <= 1'b1;
               end
            end
            S_WARMUP: begin
               if (tmr == '0) begin
                  state <= S_MEASURE;
                  tmr   <= WIN_LD;
                  cnt   <= '0;
                  dtsi1 <= 1'b1;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            S_MEASURE: begin
               if (tmr == '0) begin
                  state  <= S_DONE;
                  cnt    <= '0;
                  dtsi1  <= 1'b0;
                  valid  <= 1'b1;
                  result <= res_new;
                  alarm  <= alarm_new;
               end else begin
                  tmr <= tmr - 1'b1;
                  cnt <= sum;
               end
            end
            S_DONE: begin
               valid <= 1'b0;
               if (cont) begin
                  state <= S_MEASURE;
                  tmr   <= WIN_LD;
                  dtsi1 <= 1'b1;
               end else begin
                  state <= S_IDLE;
                  dtsi0 <= 1'b0;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               dtsi0 <= 1'b0;
               dtsi1 <= 1'b0;
               busy  <= 1'b0;
               valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dts_ctrl.sv
// Scoreboard bench for dts_ctrl: stimulus queues expected valid cycle/result/alarm,
// a negedge monitor pops and compares whenever valid is seen.
module tb_dts_ctrl;

   localparam int WARMUP_CYC = 4;
   localparam int WIN_LOG2   = 4;
   localparam int LAT        = 21;
   localparam int PER        = 17;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       start = 1'b0;
   logic       cont = 1'b0;
   logic [1:0] range = 2'b00;
   logic [3:0] thr_hi = 4'd15;
   logic [3:0] thr_lo = 4'd0;
   logic       dtso;
   logic       dtsi0, dtsi1, dtsi2, dtsi3, busy, valid, alarm;
   logic [3:0] result;

   dts_ctrl #(.WARMUP_CYC(WARMUP_CYC), .WIN_LOG2(WIN_LOG2)) dut (
      .clk(clk), .rstn(rstn), .start(start), .cont(cont), .range(range),
      .thr_hi(thr_hi), .thr_lo(thr_lo), .dtso(dtso),
      .dtsi0(dtsi0), .dtsi1(dtsi1), .dtsi2(dtsi2), .dtsi3(dtsi3),
      .busy(busy), .valid(valid), .result(result), .alarm(alarm)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // period-16 pattern: any 16 consecutive cycles hold exactly k_ones highs
   logic [3:0] phase = 4'd0;
   logic       tog = 1'b0;
   int         k_ones = 0;
   always @(negedge clk) phase <= phase + 4'd1;
   assign dtso = tog ? phase[0] : (int'(phase) < k_ones);

   typedef struct {
      int         cyc;
      logic [3:0] res;
      logic       alm;
   } exp_t;
   exp_t sbq[$];

   int   n_chk = 0;
   int   n_fail = 0;
   logic m_alarm = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int vcyc, input logic [3:0] res);
      exp_t e;
      if (res >= thr_hi)
         m_alarm = 1'b1;
      else if (res <= thr_lo)
         m_alarm = 1'b0;
      e.cyc = vcyc;
      e.res = res;
      e.alm = m_alarm;
      sbq.push_back(e);
   endtask

   always @(negedge clk) begin
      if (valid) begin
         if (sbq.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("valid_cycle", cyc, e.cyc);
            chk("result", int'(result), int'(e.res));
            chk("alarm", int'(alarm), int'(e.alm));
         end
      end
   end

   task automatic one_shot(input int k, input logic t, input logic [3:0] res);
      int t0;
      k_ones = k;
      tog = t;
      t0 = cyc;
      push(t0 + LAT, res);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (LAT + 3) @(negedge clk);
      chk("oneshot_idle_busy", int'(busy), 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_valid"}, int'(valid), 0);
      chk({tag, "_result"}, int'(result), 0);
      chk({tag, "_alarm"}, int'(alarm), 0);
      chk({tag, "_dtsi"}, int'({dtsi3, dtsi2, dtsi1, dtsi0}), 0);
   endtask

   initial begin
      int t0;
      int bad;

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rstn = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_dtsi0", int'(dtsi0), 0);

      // one-shot saturation with full checks of the sequence
      k_ones = 16;
      tog = 1'b0;
      range = 2'b10;
      t0 = cyc;
      push(t0 + LAT, 4'd15);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("warm_busy", int'(busy), 1);
      chk("warm_dtsi0", int'(dtsi0), 1);
      chk("warm_dtsi1", int'(dtsi1), 0);
      chk("warm_range", int'({dtsi3, dtsi2}), 2);
      range = 2'b01;
      repeat (9) @(negedge clk);
      chk("meas_dtsi1", int'(dtsi1), 1);
      chk("meas_range", int'({dtsi3, dtsi2}), 2);
      repeat (12) @(negedge clk);
      chk("after_busy", int'(busy), 0);
      chk("after_dtsi0", int'(dtsi0), 0);
      repeat (3) @(negedge clk);

      one_shot(0, 1'b1, 4'd8);
      one_shot(0, 1'b0, 4'd0);

      // hysteresis
      thr_hi = 4'd12;
      thr_lo = 4'd4;
      one_shot(13, 1'b0, 4'd13);
      one_shot(8, 1'b0, 4'd8);
      one_shot(3, 1'b0, 4'd3);
      thr_hi = 4'd4;
      thr_lo = 4'd12;
      one_shot(8, 1'b0, 4'd8);
      thr_hi = 4'd12;
      thr_lo = 4'd4;

      // continuous mode, cont dropped inside the fourth window
      k_ones = 10;
      tog = 1'b0;
      t0 = cyc;
      for (int i = 0; i < 4; i++) push(t0 + LAT + PER * i, 4'd10);
      cont = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bad = 0;
      while (cyc < t0 + LAT + 3 * PER) begin
         if (!dtsi0) bad++;
         if (cyc == t0 + 60) cont = 1'b0;
         @(negedge clk);
      end
      if (!dtsi0) bad++;
      chk("cont_dtsi0_low_cycles", bad, 0);
      @(negedge clk);
      chk("cont_end_busy", int'(busy), 0);
      chk("cont_end_dtsi0", int'(dtsi0), 0);
      repeat (5) @(negedge clk);

      // async reset in the middle of MEASURE
      k_ones = 16;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre_rst_dtsi1", int'(dtsi1), 1);
      #2 rstn = 1'b0;
      #1 chk_all_zero("midrst");
      m_alarm = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      repeat (30) @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);

      // start abuse and range change while busy
      k_ones = 13;
      range = 2'b11;
      t0 = cyc;
      push(t0 + LAT, 4'd13);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      range = 2'b00;
      while (cyc < t0 + 19) begin
         @(negedge clk);
         if (cyc == t0 + 15) chk("busy_range_hold", int'({dtsi3, dtsi2}), 3);
      end
      start = 1'b0;
      repeat (15) @(negedge clk);
      chk("abuse_idle_busy", int'(busy), 0);

      chk("scoreboard_empty", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
